// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter.
// Long-latency result entry layout, x0 index and starvation default.
package wb_port_arbiter_pkg;

    localparam int RD_W            = 5;
    localparam int DATA_W          = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [RD_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic              fp;
        logic              kill;
        logic [DATA_W-1:0] data;
    } lu_entry_t;

    localparam int LU_ENTRY_W = $bits(lu_entry_t);

    function automatic lu_entry_t mk_entry(
        input logic [RD_W-1:0]   rd,
        input logic              fp,
        input logic [DATA_W-1:0] data
    );
        lu_entry_t e;
        e.rd   = rd;
        e.fp   = fp;
        e.kill = 1'b0;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback arbiter and its environment.
// master drives pipeline/long-latency/query inputs; slave is the arbiter.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic        pipe_regwen;
    logic        pipe_fp_regwen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic [31:0] pipe_fp_wdata;

    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic        lu_fp;
    logic [31:0] lu_data;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fp_rf_we;
    logic [4:0]  fp_rf_waddr;
    logic [31:0] fp_rf_wdata;

    logic        stall_req;
    logic [4:0]  query_rd;
    logic        query_fp;
    logic        query_hit;
    logic [CW-1:0] buf_count;

    modport master (
        output pipe_regwen, pipe_fp_regwen, pipe_rd,
        output pipe_wdata, pipe_fp_wdata,
        output lu_valid, lu_rd, lu_fp, lu_data,
        output query_rd, query_fp,
        input  lu_ready, rf_we, rf_waddr, rf_wdata,
        input  fp_rf_we, fp_rf_waddr, fp_rf_wdata,
        input  stall_req, query_hit, buf_count
    );

    modport slave (
        input  pipe_regwen, pipe_fp_regwen, pipe_rd,
        input  pipe_wdata, pipe_fp_wdata,
        input  lu_valid, lu_rd, lu_fp, lu_data,
        input  query_rd, query_fp,
        output lu_ready, rf_we, rf_waddr, rf_wdata,
        output fp_rf_we, fp_rf_waddr, fp_rf_wdata,
        output stall_req, query_hit, buf_count
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Result buffer with per-entry kill bits and parallel rd/fp compares
// feeding both the hazard query and the WAW kill.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  lu_entry_t         i_push_entry,
    input  logic              i_pop,
    input  logic              i_kill_int,
    input  logic              i_kill_fp,
    input  logic [RD_W-1:0]   i_kill_rd,
    input  logic [RD_W-1:0]   i_q_rd,
    input  logic              i_q_fp,
    output lu_entry_t         o_head,
    output logic              o_head_vld,
    output logic [CW-1:0]     o_count,
    output logic              o_q_hit
);
    localparam int AW = $clog2(DEPTH);

    lu_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_live;
    logic [DEPTH-1:0] w_kill;
    logic [DEPTH-1:0] w_qmatch;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_count < CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_comb begin
        w_live   = '0;
        w_kill   = '0;
        w_qmatch = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i] = r_valid[i] && !r_mem[i].kill;
            w_kill[i] = w_live[i] && (r_mem[i].rd == i_kill_rd)
                && (r_mem[i].fp ? i_kill_fp : i_kill_int);
            w_qmatch[i] = w_live[i] && (r_mem[i].rd == i_q_rd)
                && (r_mem[i].fp == i_q_fp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill[i]) begin
                    r_mem[i].kill <= 1'b1;
                end
            end
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            // The incoming entry is written clean; a same-cycle kill never targets it.
            if (w_push) begin
                r_mem[r_wptr]      <= i_push_entry;
                r_mem[r_wptr].kill <= 1'b0;
                r_valid[r_wptr]    <= 1'b1;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head     = r_mem[r_rptr];
    assign o_head_vld = (r_count != '0);
    assign o_count    = r_count;
    assign o_q_hit    = |w_qmatch;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares int/FP regfile write ports between pipeline writeback and
// a buffered out-of-order long-latency unit.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    lu_entry_t     w_head;
    logic          w_head_vld;
    logic [CW-1:0] w_count;
    logic          w_fifo_hit;

    logic w_pipe_int;
    logic w_ready;
    logic w_push;
    logic w_drop;
    logic w_int_gnt;
    logic w_fp_gnt;
    logic w_pop;
    logic w_blocked;

    logic [SW-1:0] r_starve;
    logic          r_stall;

    assign w_pipe_int = bus.pipe_regwen && (bus.pipe_rd != REG_X0);
    assign w_ready    = (w_count < CW'(DEPTH));
    assign w_push     = bus.lu_valid && w_ready;

    assign w_drop = w_head_vld
        && (w_head.kill || (!w_head.fp && w_head.rd == REG_X0));
    assign w_int_gnt = w_head_vld && !w_drop && !w_head.fp
        && !w_pipe_int;
    assign w_fp_gnt = w_head_vld && !w_drop && w_head.fp
        && !bus.pipe_fp_regwen;
    assign w_pop     = w_drop || w_int_gnt || w_fp_gnt;
    assign w_blocked = w_head_vld && !w_pop;

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (mk_entry(bus.lu_rd, bus.lu_fp, bus.lu_data)),
        .i_pop        (w_pop),
        .i_kill_int   (w_pipe_int),
        .i_kill_fp    (bus.pipe_fp_regwen),
        .i_kill_rd    (bus.pipe_rd),
        .i_q_rd       (bus.query_rd),
        .i_q_fp       (bus.query_fp),
        .o_head       (w_head),
        .o_head_vld   (w_head_vld),
        .o_count      (w_count),
        .o_q_hit      (w_fifo_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_pop || !w_head_vld) begin
                r_starve <= '0;
            end else if (w_blocked && r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 1'b1;
            end
            r_stall <= w_head_vld && !w_pop
                && (r_starve == SW'(STARVE_LIMIT));
        end
    end

    assign bus.rf_we    = !rst && (w_pipe_int || w_int_gnt);
    assign bus.rf_waddr = w_int_gnt ? w_head.rd : bus.pipe_rd;
    assign bus.rf_wdata = w_int_gnt ? w_head.data : bus.pipe_wdata;

    assign bus.fp_rf_we    = !rst && (bus.pipe_fp_regwen || w_fp_gnt);
    assign bus.fp_rf_waddr = w_fp_gnt ? w_head.rd : bus.pipe_rd;
    assign bus.fp_rf_wdata = w_fp_gnt ? w_head.data : bus.pipe_fp_wdata;

    assign bus.lu_ready  = !rst && w_ready;
    assign bus.stall_req = r_stall;
    assign bus.buf_count = w_count;

    // x0 on the int file is never a real hazard.
    assign bus.query_hit = !rst && w_fifo_hit
        && (bus.query_fp || bus.query_rd != REG_X0);

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer and single FP register-file write ports between two writers:
  - the in-order pipeline writeback (writeback mux outputs);
  - an out-of-order long-latency unit (FP div/sqrt, int divider) completing via valid/ready.
- Holds long-latency results in a small FIFO and drains them into idle write-port cycles.
- Asks the front end for bubbles when a result starves.
- Reports pending destinations so hazard logic can interlock.

Parameters:
DEPTH, 2, result buffer entries (power of two, ≥2)
STARVE_LIMIT, 4, consecutive blocked cycles before stall_req asserts (≥1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
pipe_regwen  input  1  pipeline int regfile write this cycle
pipe_fp_regwen  input  1  pipeline FP regfile write this cycle
pipe_rd  input  5  pipeline destination register
pipe_wdata  input  32  pipeline int write data
pipe_fp_wdata  input  32  pipeline FP write data
lu_valid  input  1  long-latency result valid
lu_ready  output  1  buffer can accept
lu_rd  input  5  result destination
lu_fp  input  1  1 = FP regfile destination, 0 = int
lu_data  input  32  result data
rf_we  output  1  int regfile write enable
rf_waddr  output  5  int write address
rf_wdata  output  32  int write data
fp_rf_we  output  1  FP regfile write enable
fp_rf_waddr  output  5  FP write address
fp_rf_wdata  output  32  FP write data
stall_req  output  1  request one front-end bubble
query_rd  input  5  hazard query register
query_fp  input  1  hazard query regfile select
query_hit  output  1  live buffered entry targets query_rd/query_fp
buf_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count = 0; all kill bits cleared; starve counter = 0; stall_req = 0.
  - rf_we, fp_rf_we and query_hit are forced to 0 while rst is high.
  - lu_ready = 0 while rst is high, = 1 after release.
  - An in-flight lu handshake is lost; the long-latency unit is reset by the same rst.
- Port ownership:
  - The pipeline always has priority and passes combinationally (0 latency).
  - rf_we = pipe_regwen && pipe_rd≠0.
  - fp_rf_we = pipe_fp_regwen.
- Push:
  - lu_ready = (count < DEPTH), derived from registered count only; it does not depend on a same-cycle pop.
  - lu_valid && lu_ready enqueues {rd, fp, data, kill=0} at the posedge.
  - An entry becomes drain-eligible the cycle after its push (minimum buffer latency 1).
- Drain: at most one entry per cycle, head only, strictly FIFO.
  - Int head is granted when the int port is free (!(pipe_regwen && pipe_rd≠0)). It drives rf_we=1, rf_waddr=head.rd, rf_wdata=head.data, and pops.
  - FP head is granted when !pipe_fp_regwen, same scheme on the fp_rf_* outputs.
  - Head with kill=1, or int head with rd=0: pops without any write, regardless of port state.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- WAW kill:
  - If the pipeline writes the same regfile and rd as a live buffered entry, that entry's kill bit is set at the posedge. The newer pipeline value must win.
  - This applies to every matching entry, not just the head.
  - An incoming push in the same cycle is not killed.
- Starvation:
  - The counter increments each cycle a live, un-killed head is blocked by the pipeline, saturating at STARVE_LIMIT.
  - The counter clears on any pop, or when the buffer is empty.
  - stall_req is registered: it is 1 in the cycle after the counter reaches STARVE_LIMIT and holds until the head pops.
- query_hit: combinational OR over valid, non-killed entries of (rd==query_rd && fp==query_fp). query_fp=0 with query_rd=0 always gives 0.
- Full and blocked: lu_ready=0 back-pressures the unit; there is no data loss and no overflow.

Decomposition:
- Shared package/header (alongside control_sel.vh):
  - the `LU_ENTRY_W` field layout (rd, fp, kill, data);
  - the STARVE_LIMIT default;
  - the x0 index constant.
- Sub-module wb_result_fifo: DEPTH-entry FIFO with per-entry kill bits and a parallel rd/fp compare vector. It feeds both query_hit and WAW kill.
- Arbitration, starve counter and port muxing live in the top module.

Test Plan:
- Idle pipeline: push {rd=5, int, 0xDEADBEEF} at cycle 0 → cycle 1 rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; buf_count back to 0 at cycle 2.
- Priority: pipe_regwen=1 with rd=3 held for 3 cycles, buffered int entry rd=7 → rf_waddr=3 each cycle; rd=7 written the first cycle pipe_regwen=0. A buffered FP entry drains during the same period.
- Starvation: int port blocked for 6 cycles, STARVE_LIMIT=4 → stall_req=1 from cycle 5. Dropping pipe_regwen drains the entry, and stall_req=0 the next cycle.
- Full: 3 back-to-back lu_valid with DEPTH=2 and port blocked → lu_ready=0 after 2 pushes, third result held. Unblock → all three written in push order, none lost.
- WAW kill: buffer holds FP f4=0x3F800000; pipeline writes f4=0x40000000 → fp_rf_wdata=0x40000000, entry later pops with fp_rf_we=0, and query_hit(f4) drops to 0 after the kill.
- Reset mid-operation: assert rst with 2 entries and stall_req=1 → immediately buf_count=0, stall_req=0, rf_we=0, lu_ready=0. After release: lu_ready=1 and no stale writes.
